// File: rtl/trigger_readout_pkg.sv
// Shared definitions for the trigger readout path and the acquisition stage
// that feeds it.
package trigger_readout_pkg;

  localparam int RAM_WIDTH_DEF = 10;
  localparam int NCH_DEF       = 4;
  localparam int RD_LAT_DEF    = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    ISSUE,
    WAIT_DATA,
    SEND,
    FIN
  } state_t;

  // Width of a channel index; at least one bit so single-channel builds elaborate.
  function automatic int chan_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trigger_readout_if.sv
// Byte stream from the readout block to the host transmit path.
// A byte transfers on a clock edge where tx_valid && tx_ready; once tx_valid rises, tx_data is held until that edge.
interface trigger_readout_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/trigger_readout_chan_sel.sv
// Priority finder: lowest enabled channel whose index is >= from, or none.
module trigger_readout_chan_sel
  import trigger_readout_pkg::*;
#(
  parameter int N = NCH_DEF,
  localparam int CW = chan_idx_width(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [CW:0]   from,
  output logic [CW-1:0] next_ch,
  output logic          none
);

  // Scanning downward lets the lowest qualifying index win.
  always_comb begin
    next_ch = '0;
    none    = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && ((CW + 1)'(i) >= from)) begin
        next_ch = CW'(i);
        none    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/trigger_readout.sv
// Walks the circular sample RAM from the pre-trigger origin and streams each
// enabled channel's bytes to the host, one RAM read per byte.
module trigger_readout
  import trigger_readout_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int NCH       = NCH_DEF,
  parameter int RD_LAT    = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_read,
  input  logic [RAM_WIDTH:0]   nsamples,
  input  logic [NCH-1:0]       chan_mask,
  input  logic                 auto_rearm,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
  input  logic [RAM_WIDTH-1:0] triggerpoint,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  input  logic [8*NCH-1:0]     ram_q,
  trigger_readout_if.master    tx,
  output logic                 busy,
  output logic                 done,
  output logic                 start_trigger,
  output state_t               dbg_state
);

  localparam int CW = chan_idx_width(NCH);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
  localparam logic [RAM_WIDTH:0] ONE = (RAM_WIDTH + 1)'(1);

  state_t               state;
  logic [RAM_WIDTH:0]   ns_q;
  logic [NCH-1:0]       mask_q;
  logic                 rearm_q;
  logic [RAM_WIDTH-1:0] base;
  logic [CW-1:0]        ch;
  logic [RAM_WIDTH:0]   count;
  logic [LW-1:0]        lat;
  logic [7:0]           tx_data_q;
  logic                 tx_valid_q;

  logic [RAM_WIDTH-1:0] base_new;
  logic [CW:0]          sel_from;
  logic [CW-1:0]        sel_ch;
  logic                 sel_none;

  assign base_new     = wraddress_triggerpoint - triggerpoint;
  assign sel_from     = (state == WAIT_READY) ? '0 : ({1'b0, ch} + (CW + 1)'(1));
  assign tx.tx_data   = tx_data_q;
  assign tx.tx_valid  = tx_valid_q;
  assign dbg_state    = state;

  trigger_readout_chan_sel #(.N(NCH)) u_chan_sel (
    .mask    (mask_q),
    .from    (sel_from),
    .next_ch (sel_ch),
    .none    (sel_none)
  );

  // rden is raised on entry to ISSUE so it is high exactly for the ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rden          <= 1'b0;
      rdaddress     <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      start_trigger <= 1'b0;
      ns_q          <= '0;
      mask_q        <= '0;
      rearm_q       <= 1'b0;
      base          <= '0;
      ch            <= '0;
      count         <= '0;
      lat           <= '0;
    end else begin
      done          <= 1'b0;
      start_trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (start_read) begin
            ns_q    <= nsamples;
            mask_q  <= chan_mask;
            rearm_q <= auto_rearm;
            busy    <= 1'b1;
            state   <= (nsamples == '0 || chan_mask == '0) ? FIN : WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (data_ready) begin
            base      <= base_new;
            rdaddress <= base_new;
            ch        <= sel_ch;
            count     <= '0;
            rden      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          rden  <= 1'b0;
          lat   <= '0;
          state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (lat == LAT_LAST) begin
            tx_data_q  <= ram_q[8*ch +: 8];
            tx_valid_q <= 1'b1;
            state      <= SEND;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        SEND: begin
          if (tx.tx_ready) begin
            tx_valid_q <= 1'b0;
            if (count == ns_q - ONE) begin
              if (sel_none) begin
                state <= FIN;
              end else begin
                ch        <= sel_ch;
                count     <= '0;
                rdaddress <= base;
                rden      <= 1'b1;
                state     <= ISSUE;
              end
            end else begin
              count     <= count + ONE;
              rdaddress <= rdaddress + 1'b1;
              rden      <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        FIN: begin
          done          <= 1'b1;
          start_trigger <= rearm_q;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_readout.sv
// Bench for trigger_readout: RAM model with read latency, randomized RAM contents
// and handshake, and a reference list of addresses/bytes built from the readout rules.
module tb_trigger_readout;
  import trigger_readout_pkg::*;

  localparam int RW = 10;
  localparam int NC = 4;
  localparam int DEPTH = 1 << RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            start_read = 1'b0;
  logic [RW:0]     nsamples = '0;
  logic [NC-1:0]   chan_mask = '0;
  logic            auto_rearm = 1'b0;
  logic            data_ready = 1'b0;
  logic [RW-1:0]   wtp = '0;
  logic [RW-1:0]   tp = '0;
  logic            rden;
  logic [RW-1:0]   rdaddress;
  logic [8*NC-1:0] ram_q = '0;
  logic [8*NC-1:0] q1 = '0;
  logic            busy;
  logic            done;
  logic            start_trigger;
  state_t          dbg_state;

  trigger_readout_if tx_if ();

  trigger_readout dut (
    .clk                    (clk),
    .reset                  (reset),
    .start_read             (start_read),
    .nsamples               (nsamples),
    .chan_mask              (chan_mask),
    .auto_rearm             (auto_rearm),
    .data_ready             (data_ready),
    .wraddress_triggerpoint (wtp),
    .triggerpoint           (tp),
    .rden                   (rden),
    .rdaddress              (rdaddress),
    .ram_q                  (ram_q),
    .tx                     (tx_if.master),
    .busy                   (busy),
    .done                   (done),
    .start_trigger          (start_trigger),
    .dbg_state              (dbg_state)
  );

  // Sample RAM: data appears two cycles after the address is presented.
  logic [8*NC-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rden) q1 <= mem[rdaddress];
    ram_q <= q1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [RW-1:0] obs_addr[$];
  logic [RW-1:0] exp_addr[$];
  logic [7:0]    obs_q[$];
  logic [7:0]    exp_q[$];
  int done_cnt, st_cnt, st_alone, viol_rden, viol_stable;
  bit bp_en = 1'b0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) tx_if.tx_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (rden) obs_addr.push_back(rdaddress);
        if (tx_if.tx_valid && tx_if.tx_ready) obs_q.push_back(tx_if.tx_data);
        if (rden && tx_if.tx_valid) viol_rden++;
        if (prev_hold && (!tx_if.tx_valid || tx_if.tx_data !== prev_data)) viol_stable++;
        if (done) done_cnt++;
        if (start_trigger) st_cnt++;
        if (start_trigger && !done) st_alone++;
        prev_hold = tx_if.tx_valid && !tx_if.tx_ready;
        prev_data = tx_if.tx_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Reference: channel-major, ascending channel, addresses base..base+ns-1 modulo depth.
  task automatic build_model(input logic [RW-1:0] trig, input logic [RW-1:0] pre,
                             input int ns, input logic [NC-1:0] m);
    logic [RW-1:0] b;
    logic [RW-1:0] a;
    logic [8*NC-1:0] w;
    exp_addr.delete();
    exp_q.delete();
    b = RW'((int'(trig) - int'(pre) + DEPTH) % DEPTH);
    for (int c = 0; c < NC; c++) begin
      if (m[c]) begin
        for (int k = 0; k < ns; k++) begin
          a = RW'((int'(b) + k) % DEPTH);
          w = mem[a];
          exp_addr.push_back(a);
          exp_q.push_back(w[8*c +: 8]);
        end
      end
    end
  endtask

  task automatic start_readout(input logic [RW-1:0] trig, input logic [RW-1:0] pre,
                               input int ns, input logic [NC-1:0] m, input logic rearm);
    build_model(trig, pre, ns, m);
    obs_addr.delete();
    obs_q.delete();
    done_cnt = 0;
    st_cnt = 0;
    st_alone = 0;
    @(negedge clk);
    wtp = trig;
    tp = pre;
    nsamples = ns[RW:0];
    chan_mask = m;
    auto_rearm = rearm;
    start_read = 1'b1;
    @(negedge clk);
    start_read = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int byte_errs();
    int e = 0;
    if (obs_q.size() != exp_q.size()) e++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic int addr_errs();
    int e = 0;
    if (obs_addr.size() != exp_addr.size()) e++;
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
      if (obs_addr[i] !== exp_addr[i]) e++;
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rden !== 1'b0) $display("FAIL reset_rden: got %b want 0", rden); else n_pass++;
    n_checks++; if (rdaddress !== '0) $display("FAIL reset_rdaddress: got %0h want 0", rdaddress); else n_pass++;
    n_checks++; if (tx_if.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_if.tx_valid); else n_pass++;
    n_checks++; if (tx_if.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %0h want 0", tx_if.tx_data); else n_pass++;
    n_checks++; if ({busy, done, start_trigger} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, start_trigger}); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    data_ready = 1'b1;
    start_readout(10'h100, 10'h080, 4, 4'b0001, 1'b0);
    wait_done(200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL basic_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if (obs_q.size() !== 4) $display("FAIL basic_count: got %0d want 4", obs_q.size()); else n_pass++;
    n_checks++; if (obs_addr.size() < 1 || obs_addr[0] !== 10'h080) $display("FAIL basic_first_addr: got %0h want 80", (obs_addr.size() > 0) ? obs_addr[0] : 10'h3ff); else n_pass++;
    n_checks++; if (addr_errs() !== 0) $display("FAIL basic_addr: got %0d errors want 0", addr_errs()); else n_pass++;
    n_checks++; if (byte_errs() !== 0) $display("FAIL basic_bytes: got %0d errors want 0", byte_errs()); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt); else n_pass++;
    n_checks++; if (st_cnt !== 0) $display("FAIL basic_start_trigger: got %0d pulses want 0", st_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    start_readout(10'h010, 10'h020, 64, 4'b0001, 1'b0);
    wait_done(1000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL wrap_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if (obs_addr.size() < 17 || obs_addr[0] !== 10'h3f0 || obs_addr[15] !== 10'h3ff || obs_addr[16] !== 10'h000)
      $display("FAIL wrap_edges: got size %0d want 64 with 3f0/3ff/000 at 0/15/16", obs_addr.size()); else n_pass++;
    n_checks++; if (addr_errs() !== 0) $display("FAIL wrap_addr: got %0d errors want 0", addr_errs()); else n_pass++;
    n_checks++; if (byte_errs() !== 0) $display("FAIL wrap_bytes: got %0d errors want 0", byte_errs()); else n_pass++;
  endtask

  task automatic test_mask();
    bit ok;
    start_readout(10'h2a5, 10'h005, 2, 4'b1010, 1'b0);
    wait_done(200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL mask_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if (obs_q.size() !== 4) $display("FAIL mask_count: got %0d want 4", obs_q.size()); else n_pass++;
    n_checks++; if (byte_errs() !== 0) $display("FAIL mask_order: got %0d errors want 0", byte_errs()); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int ns;
    bp_en = 1'b1;
    viol_rden = 0;
    viol_stable = 0;
    for (int it = 0; it < 4; it++) begin
      ns = $urandom_range(1, 24);
      start_readout(RW'($urandom_range(0, DEPTH - 1)), RW'($urandom_range(0, DEPTH - 1)),
                    ns, NC'($urandom_range(1, 15)), 1'b0);
      wait_done(5000, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL bp_timeout[%0d]: got %b want 1", it, ok); else n_pass++;
      n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL bp_count[%0d]: got %0d want %0d", it, obs_q.size(), exp_q.size()); else n_pass++;
      n_checks++; if (byte_errs() !== 0) $display("FAIL bp_bytes[%0d]: got %0d errors want 0", it, byte_errs()); else n_pass++;
    end
    bp_en = 1'b0;
    @(negedge clk);
    tx_if.tx_ready = 1'b1;
    n_checks++; if (viol_stable !== 0) $display("FAIL bp_stable: got %0d violations want 0", viol_stable); else n_pass++;
    n_checks++; if (viol_rden !== 0) $display("FAIL bp_rden_while_valid: got %0d violations want 0", viol_rden); else n_pass++;
  endtask

  task automatic test_degenerate();
    bit ok;
    start_readout(10'h123, 10'h011, 0, 4'b1111, 1'b0);
    n_checks++; if (done !== 1'b0) $display("FAIL zero_done_early: got %b want 0", done); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done_at_2: got %b want 1", done); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (obs_q.size() + obs_addr.size() !== 0) $display("FAIL zero_traffic: got %0d want 0", obs_q.size() + obs_addr.size()); else n_pass++;
    start_readout(10'h000, 10'h000, 3, 4'b0000, 1'b0);
    wait_done(20, ok);
    n_checks++; if (ok !== 1'b1 || obs_q.size() !== 0) $display("FAIL nomask: got ok %b bytes %0d want 1/0", ok, obs_q.size()); else n_pass++;
  endtask

  task automatic test_full();
    bit ok;
    int hits[DEPTH];
    int bad = 0;
    start_readout(10'h3c7, 10'h1f2, DEPTH, 4'b0001, 1'b0);
    wait_done(8000, ok);
    foreach (hits[i]) hits[i] = 0;
    foreach (obs_addr[i]) hits[obs_addr[i]]++;
    foreach (hits[i]) if (hits[i] != 1) bad++;
    n_checks++; if (ok !== 1'b1) $display("FAIL full_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if (obs_q.size() !== DEPTH) $display("FAIL full_count: got %0d want %0d", obs_q.size(), DEPTH); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL full_once: got %0d addresses not read once want 0", bad); else n_pass++;
    n_checks++; if (byte_errs() !== 0) $display("FAIL full_bytes: got %0d errors want 0", byte_errs()); else n_pass++;
  endtask

  task automatic test_rearm();
    bit ok;
    start_readout(10'h050, 10'h010, 3, 4'b0110, 1'b1);
    wait_done(300, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL rearm_timeout: got %b want 1", ok); else n_pass++;
    n_checks++; if (st_cnt !== 1) $display("FAIL rearm_pulse: got %0d want 1", st_cnt); else n_pass++;
    n_checks++; if (st_alone !== 0) $display("FAIL rearm_with_done: got %0d stray want 0", st_alone); else n_pass++;
  endtask

  task automatic test_gating();
    bit ok;
    data_ready = 1'b0;
    start_readout(10'h200, 10'h100, 5, 4'b1001, 1'b0);
    repeat (50) @(negedge clk);
    n_checks++; if (obs_addr.size() !== 0) $display("FAIL gate_no_rden: got %0d reads want 0", obs_addr.size()); else n_pass++;
    data_ready = 1'b1;
    wait_done(500, ok);
    n_checks++; if (ok !== 1'b1 || byte_errs() !== 0) $display("FAIL gate_after: got ok %b errors %0d want 1/0", ok, byte_errs()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    tx_if.tx_ready = 1'b0;
    start_readout(10'h0f0, 10'h0a0, 6, 4'b0011, 1'b1);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = tx_if.tx_valid;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL rst_reach_send: got %b want 1", seen); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_async: got valid %b busy %b want 0/0", tx_if.tx_valid, busy); else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tx_if.tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (done_cnt + st_cnt !== 0) $display("FAIL rst_no_pulse: got %0d pulses want 0", done_cnt + st_cnt); else n_pass++;
    start_readout(10'h0f0, 10'h0a0, 6, 4'b0011, 1'b0);
    wait_done(500, ok);
    n_checks++; if (ok !== 1'b1 || byte_errs() !== 0) $display("FAIL rst_recover: got ok %b errors %0d want 1/0", ok, byte_errs()); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_wrap();
    test_mask();
    test_backpressure();
    test_degenerate();
    test_full();
    test_rearm();
    test_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
